segment_7: RTL and testbench

Registered BCD/hex-to-seven-segment decoder. It converts a 4-bit digit code into the seven segment-drive lines a–g of a single display digit. It sits between digit-producing logic (counters, multiplexed display scanners) and the display pins. The output is registered on one clock for glitch-free pin drive, and it supports blanking, lamp test and selectable output polarity.

---
 rtl/segment_7.sv | 73 +++++++
 tb/tb_segment_7.sv | 138 +++++++++++++
 2 files changed

// File: rtl/segment_7.sv
// segment_7: registered BCD/hex to seven-segment decoder with blanking,
// lamp test and selectable output polarity. seg bit order is {g,f,e,d,c,b,a}.
module segment_7 #(
  parameter bit HEX_MODE   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg
);

  // Lit patterns in active-high form {g,f,e,d,c,b,a}.
  localparam logic [6:0] LIT_ALL  = 7'h7F;
  localparam logic [6:0] LIT_NONE = 7'h00;

  // Pattern that turns every segment off, in the selected output polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] digit_lit;
  logic [6:0] lit_d;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Decode the digit code into its active-high segment pattern.
  always_comb begin
    digit_lit = LIT_NONE;
    unique case (bcd)
      4'd0:  digit_lit = 7'h3F;
      4'd1:  digit_lit = 7'h06;
      4'd2:  digit_lit = 7'h5B;
      4'd3:  digit_lit = 7'h4F;
      4'd4:  digit_lit = 7'h66;
      4'd5:  digit_lit = 7'h6D;
      4'd6:  digit_lit = 7'h7D;
      4'd7:  digit_lit = 7'h07;
      4'd8:  digit_lit = 7'h7F;
      4'd9:  digit_lit = 7'h6F;
      4'd10: digit_lit = HEX_MODE ? 7'h77 : LIT_NONE;
      4'd11: digit_lit = HEX_MODE ? 7'h7C : LIT_NONE;
      4'd12: digit_lit = HEX_MODE ? 7'h39 : LIT_NONE;
      4'd13: digit_lit = HEX_MODE ? 7'h5E : LIT_NONE;
      4'd14: digit_lit = HEX_MODE ? 7'h79 : LIT_NONE;
      4'd15: digit_lit = HEX_MODE ? 7'h71 : LIT_NONE;
      default: digit_lit = LIT_NONE;
    endcase
  end

  // Apply lamp test over blanking over the decode, then output polarity.
  always_comb begin
    lit_d = digit_lit;
    if (lamp_test) begin
      lit_d = LIT_ALL;
    end else if (blank) begin
      lit_d = LIT_NONE;
    end
    seg_d = ACTIVE_LOW ? ~lit_d : lit_d;
  end

  // Output register: pins are driven only from flops; reset forces all off.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;

endmodule

// File: tb/tb_segment_7.sv
// tb_segment_7: directed checks of segment_7 with default parameters and
// with HEX_MODE=0 / ACTIVE_LOW=0, both instances sharing the same inputs.
`timescale 1ns/1ps
module tb_segment_7;

  logic       clk;
  logic       rst;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_def;
  logic [6:0] seg_alt;

  int errors = 0;
  int checks = 0;

  // Expected default-instance outputs (~L) for bcd 0..15.
  logic [6:0] exp_def [16];
  // Expected HEX_MODE=0, ACTIVE_LOW=0 outputs (L) for bcd 0..15.
  logic [6:0] exp_alt [16];

  segment_7 dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg       (seg_def)
  );

  segment_7 #(.HEX_MODE(1'b0), .ACTIVE_LOW(1'b0)) dut_alt (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg       (seg_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 7'h%02h expected 7'h%02h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_def[0]  = 7'h40; exp_def[1]  = 7'h79; exp_def[2]  = 7'h24; exp_def[3]  = 7'h30;
    exp_def[4]  = 7'h19; exp_def[5]  = 7'h12; exp_def[6]  = 7'h02; exp_def[7]  = 7'h78;
    exp_def[8]  = 7'h00; exp_def[9]  = 7'h10; exp_def[10] = 7'h08; exp_def[11] = 7'h03;
    exp_def[12] = 7'h46; exp_def[13] = 7'h21; exp_def[14] = 7'h06; exp_def[15] = 7'h0E;

    exp_alt[0]  = 7'h3F; exp_alt[1]  = 7'h06; exp_alt[2]  = 7'h5B; exp_alt[3]  = 7'h4F;
    exp_alt[4]  = 7'h66; exp_alt[5]  = 7'h6D; exp_alt[6]  = 7'h7D; exp_alt[7]  = 7'h07;
    exp_alt[8]  = 7'h7F; exp_alt[9]  = 7'h6F; exp_alt[10] = 7'h00; exp_alt[11] = 7'h00;
    exp_alt[12] = 7'h00; exp_alt[13] = 7'h00; exp_alt[14] = 7'h00; exp_alt[15] = 7'h00;

    // Reset with lamp test active: reset wins, all off.
    rst = 1'b1; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      $display("reset cycle %0d: seg_def=%02h seg_alt=%02h", i, seg_def, seg_alt);
      check("reset_def", seg_def, 7'h7F);
      check("reset_alt", seg_alt, 7'h00);
    end

    // Release reset: first edge decodes digit 8 directly.
    rst = 1'b0; lamp_test = 1'b0;
    tick();
    $display("release bcd=8: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("release_def", seg_def, 7'h00);
    check("release_alt", seg_alt, 7'h7F);

    // Full sweep 0..15, one code per cycle.
    for (int i = 0; i < 16; i++) begin
      bcd = 4'(i);
      tick();
      $display("sweep bcd=%0d: seg_def=%02h seg_alt=%02h", i, seg_def, seg_alt);
      check($sformatf("sweep_def_%0d", i), seg_def, exp_def[i]);
      check($sformatf("sweep_alt_%0d", i), seg_alt, exp_alt[i]);
    end

    // Priority: blank, then lamp_test over blank, then normal.
    bcd = 4'd3; blank = 1'b1;
    tick();
    $display("blank bcd=3: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("blank_def", seg_def, 7'h7F);
    check("blank_alt", seg_alt, 7'h00);
    lamp_test = 1'b1;
    tick();
    $display("lamp+blank: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("lamp_def", seg_def, 7'h00);
    check("lamp_alt", seg_alt, 7'h7F);
    blank = 1'b0; lamp_test = 1'b0;
    tick();
    $display("normal bcd=3: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("unblank_def", seg_def, 7'h30);
    check("unblank_alt", seg_alt, 7'h4F);

    // Back-to-back 1,7,1,7: each shows exactly one edge later.
    for (int i = 0; i < 4; i++) begin
      bcd = (i % 2 == 0) ? 4'd1 : 4'd7;
      tick();
      $display("toggle bcd=%0d: seg_def=%02h", bcd, seg_def);
      check($sformatf("toggle_def_%0d", i), seg_def, (i % 2 == 0) ? 7'h79 : 7'h78);
    end

    // Mid-stream reset for one cycle at bcd=5.
    bcd = 4'd4;
    tick();
    $display("stream bcd=4: seg_def=%02h", seg_def);
    check("stream4_def", seg_def, 7'h19);
    bcd = 4'd5; rst = 1'b1;
    tick();
    $display("stream bcd=5 rst: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("midrst_def", seg_def, 7'h7F);
    check("midrst_alt", seg_alt, 7'h00);
    bcd = 4'd6; rst = 1'b0;
    tick();
    $display("stream bcd=6: seg_def=%02h seg_alt=%02h", seg_def, seg_alt);
    check("after_rst_def", seg_def, 7'h02);
    check("after_rst_alt", seg_alt, 7'h7D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
